// File: rtl/plru_pkg.sv
// Shared types and tree-path helpers for the pseudo-LRU replacement controller.
// Heap order: node 0 is the root, the children of node i are 2i+1 and 2i+2.
package plru_pkg;

    localparam int MAX_NODES = 15;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } plru_state_e;

    function automatic int tree_width(input int ways);
        return ways - 1;
    endfunction

    // Heap index of the node that sits at depth 'level' on the path to 'way'.
    function automatic int path_node(input int way, input int levels, input int level);
        int node;
        node = 0;
        for (int l = 0; l < level; l++) begin
            node = 2 * node + 1 + ((way >> (levels - 1 - l)) & 1);
        end
        return node;
    endfunction

    // Convert a leaf heap index back to a way number.
    function automatic int leaf_way(input int node, input int ways);
        return node - (ways - 1);
    endfunction

    function automatic logic [MAX_NODES-1:0] path_mask(input int way, input int levels);
        logic [MAX_NODES-1:0] m;
        m = '0;
        for (int l = 0; l < levels; l++) begin
            m = m | (MAX_NODES'(1) << path_node(way, levels, l));
        end
        return m;
    endfunction

    // Value each path node must take so that it points away from 'way'.
    function automatic logic [MAX_NODES-1:0] path_bits(input int way, input int levels);
        logic [MAX_NODES-1:0] b;
        b = '0;
        for (int l = 0; l < levels; l++) begin
            if (((way >> (levels - 1 - l)) & 1) == 0) begin
                b = b | (MAX_NODES'(1) << path_node(way, levels, l));
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/plru_tree_update.sv
// Combinational tree-bit update: marks 'way_i' as most recently used by
// pointing every node on its path away from it; off-path nodes pass through.
module plru_tree_update
    import plru_pkg::*;
#(
    parameter int WAYS = 8
) (
    input  logic [WAYS-2:0]         tree_i,
    input  logic [$clog2(WAYS)-1:0] way_i,
    output logic [WAYS-2:0]         tree_o
);

    localparam int LEVELS = $clog2(WAYS);
    localparam int TW     = tree_width(WAYS);

    logic [TW-1:0] mask;
    logic [TW-1:0] bits;

    always_comb begin
        mask   = TW'(path_mask(int'(way_i), LEVELS));
        bits   = TW'(path_bits(int'(way_i), LEVELS));
        tree_o = (tree_i & ~mask) | (bits & mask);
    end

endmodule

// File: rtl/plru_tree.sv
// Tree pseudo-LRU controller: per-set tree storage, read/fill updates with
// same-set merge, victim selection with invalid priority and lock steering.
module plru_tree
    import plru_pkg::*;
#(
    parameter int SETS = 256,
    parameter int WAYS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    UpdateEn,
    input  logic [$clog2(SETS)-1:0] ReadSet,
    input  logic [$clog2(WAYS)-1:0] ReadWay,
    input  logic                    ReadAccess,
    input  logic [$clog2(SETS)-1:0] WriteSet,
    input  logic [$clog2(WAYS)-1:0] WriteWay,
    input  logic                    WriteAccess,
    input  logic [WAYS-1:0]         ValidMask,
    input  logic [WAYS-1:0]         LockMask,
    input  logic                    FlushReq,
    output logic [$clog2(WAYS)-1:0] LRU_Way,
    output logic                    LRU_Valid,
    output logic                    InitBusy
);

    localparam int SW     = $clog2(SETS);
    localparam int LW     = $clog2(WAYS);
    localparam int TW     = tree_width(WAYS);
    localparam int NW     = $clog2(2 * WAYS);
    localparam int LEVELS = $clog2(WAYS);

    plru_state_e   state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          init_busy;

    logic [TW-1:0] tree_mem [SETS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                if (cnt_q == SW'(SETS - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (FlushReq) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_comb begin
        init_busy = (state_q == ST_INIT);
        InitBusy  = init_busy;
    end

    logic          rd_upd, wr_upd, same_set;
    logic [TW-1:0] rd_old, wr_old, rd_new, wr_base, wr_new;
    logic          p0_en;
    logic [SW-1:0] p0_set;
    logic [TW-1:0] p0_data;

    assign rd_old   = tree_mem[ReadSet];
    assign wr_old   = tree_mem[WriteSet];
    assign rd_upd   = !init_busy && UpdateEn && ReadAccess;
    assign wr_upd   = !init_busy && UpdateEn && WriteAccess;
    assign same_set = (ReadSet == WriteSet);
    // Same-set hit and fill: the fill update is layered on the read result.
    assign wr_base  = (rd_upd && same_set) ? rd_new : wr_old;

    plru_tree_update #(.WAYS(WAYS)) u_rd_upd (
        .tree_i (rd_old),
        .way_i  (ReadWay),
        .tree_o (rd_new)
    );

    plru_tree_update #(.WAYS(WAYS)) u_wr_upd (
        .tree_i (wr_base),
        .way_i  (WriteWay),
        .tree_o (wr_new)
    );

    always_comb begin
        p0_set  = ReadSet;
        p0_data = rd_new;
        p0_en   = rd_upd && !(wr_upd && same_set);
        if (init_busy) begin
            p0_en   = 1'b1;
            p0_set  = cnt_q;
            p0_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (p0_en) tree_mem[p0_set] <= p0_data;
        if (wr_upd) tree_mem[WriteSet] <= wr_new;
    end

    // lk[n] is set when every way under heap node n is locked; leaves follow.
    logic [2*WAYS-2:0] lk;
    logic [2*WAYS-2:0] tree_ext;

    assign tree_ext = {{WAYS{1'b0}}, wr_old};

    for (genvar i = 0; i < WAYS; i++) begin : g_leaf_lk
        assign lk[WAYS-1+i] = LockMask[i];
    end

    for (genvar n = 0; n < WAYS - 1; n++) begin : g_node_lk
        localparam int LVL  = $clog2(n + 2) - 1;
        localparam int POS  = n - (2 ** LVL - 1);
        localparam int SPAN = WAYS >> LVL;
        assign lk[n] = &LockMask[POS*SPAN +: SPAN];
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_walk
        logic [NW-1:0] node, left, right, nxt;
        logic          go_up;
        if (l == 0) begin : g_root
            assign node = '0;
        end else begin : g_child
            assign node = g_walk[l-1].nxt;
        end
        assign left  = {node[NW-2:0], 1'b1};
        assign right = left + 1'b1;
        assign go_up = lk[left] || (!lk[right] && tree_ext[node]);
        assign nxt   = go_up ? right : left;
    end

    logic [LW-1:0] tree_way, inv_way;
    logic          inv_found;

    assign tree_way = LW'(leaf_way(int'(g_walk[LEVELS-1].nxt), WAYS));

    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!ValidMask[i] && !LockMask[i]) begin
                inv_found = 1'b1;
                inv_way   = LW'(i);
            end
        end
    end

    always_comb begin
        LRU_Valid = 1'b0;
        LRU_Way   = '0;
        if (!init_busy && !lk[0]) begin
            LRU_Valid = 1'b1;
            LRU_Way   = inv_found ? inv_way : tree_way;
        end
    end

endmodule

// File: tb/tb_plru_tree.sv
// Self-checking bench for plru_tree (SETS=4, WAYS=4): directed scenarios
// followed by randomized traffic against a behavioural pseudo-LRU model.
module tb_plru_tree;

    localparam int SETS   = 4;
    localparam int WAYS   = 4;
    localparam int LEVELS = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       UpdateEn;
    logic [1:0] ReadSet, ReadWay, WriteSet, WriteWay;
    logic       ReadAccess, WriteAccess, FlushReq;
    logic [3:0] ValidMask, LockMask;
    logic [1:0] LRU_Way;
    logic       LRU_Valid, InitBusy;

    int n_checks = 0;
    int n_errors = 0;

    int mt [SETS][WAYS-1];
    bit m_busy;
    int m_cnt;

    plru_tree #(.SETS(SETS), .WAYS(WAYS)) dut (
        .clk         (clk),
        .rst         (rst),
        .UpdateEn    (UpdateEn),
        .ReadSet     (ReadSet),
        .ReadWay     (ReadWay),
        .ReadAccess  (ReadAccess),
        .WriteSet    (WriteSet),
        .WriteWay    (WriteWay),
        .WriteAccess (WriteAccess),
        .ValidMask   (ValidMask),
        .LockMask    (LockMask),
        .FlushReq    (FlushReq),
        .LRU_Way     (LRU_Way),
        .LRU_Valid   (LRU_Valid),
        .InitBusy    (InitBusy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void m_clear();
        for (int s = 0; s < SETS; s++)
            for (int n = 0; n < WAYS - 1; n++) mt[s][n] = 0;
    endfunction

    // Every node on the way's path is turned to face the other half.
    function automatic void m_touch(input int s, input int w);
        int node, half;
        node = 0;
        for (int l = 0; l < LEVELS; l++) begin
            half = (w >> (LEVELS - 1 - l)) & 1;
            mt[s][node] = 1 - half;
            node = 2 * node + 1 + half;
        end
    endfunction

    function automatic bit all_locked(input logic [3:0] lk, input int lo, input int n);
        bit r;
        r = 1'b1;
        for (int i = lo; i < lo + n; i++) if (!lk[i]) r = 1'b0;
        return r;
    endfunction

    function automatic void m_victim(input int s, input logic [3:0] vm, input logic [3:0] lk,
                                     output int valid, output int way);
        int lo, size, node, dir, half;
        valid = 0;
        way   = 0;
        if (m_busy || all_locked(lk, 0, WAYS)) return;
        valid = 1;
        for (int w = 0; w < WAYS; w++) begin
            if (!vm[w] && !lk[w]) begin
                way = w;
                return;
            end
        end
        lo = 0; size = WAYS; node = 0;
        while (size > 1) begin
            half = size / 2;
            dir  = mt[s][node];
            if (dir == 0 && all_locked(lk, lo, half)) dir = 1;
            else if (dir == 1 && all_locked(lk, lo + half, half)) dir = 0;
            lo   = lo + dir * half;
            node = 2 * node + 1 + dir;
            size = half;
        end
        way = lo;
    endfunction

    // One clock cycle of traffic, driven from a falling edge, ends on a falling edge.
    task automatic step(input bit re, input int rs, input int rw, input bit we,
                        input int ws, input int ww, input bit ue, input bit fl);
        bit was_busy;
        ReadAccess  = re;  ReadSet  = 2'(rs); ReadWay  = 2'(rw);
        WriteAccess = we;  WriteSet = 2'(ws); WriteWay = 2'(ww);
        UpdateEn    = ue;  FlushReq = fl;
        @(posedge clk);
        was_busy = m_busy;
        if (!was_busy && ue) begin
            if (re) m_touch(rs, rw);
            if (we) m_touch(ws, ww);
        end
        if (was_busy) begin
            m_cnt++;
            if (m_cnt == SETS) m_busy = 1'b0;
        end else if (fl) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            m_clear();
        end
        @(negedge clk);
        ReadAccess = 1'b0; WriteAccess = 1'b0; FlushReq = 1'b0;
    endtask

    task automatic victim_is(input string tag, input int s, input logic [3:0] vm,
                             input logic [3:0] lk, input int ev, input int ew);
        WriteSet = 2'(s); ValidMask = vm; LockMask = lk;
        #1;
        chk({tag, "_valid"}, LRU_Valid, ev);
        chk({tag, "_way"}, LRU_Way, ew);
    endtask

    task automatic check_model(input int s, input logic [3:0] vm, input logic [3:0] lk);
        int ev, ew;
        WriteSet = 2'(s); ValidMask = vm; LockMask = lk;
        #1;
        m_victim(s, vm, lk, ev, ew);
        chk("rnd_busy", InitBusy, m_busy);
        chk("rnd_valid", LRU_Valid, ev);
        chk("rnd_way", LRU_Way, ew);
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (InitBusy && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, n, SETS);
        m_busy = 1'b0;
        m_cnt  = 0;
        m_clear();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        UpdateEn = 1'b1;
        ReadSet = '0; ReadWay = '0; ReadAccess = 1'b0;
        WriteSet = '0; WriteWay = '0; WriteAccess = 1'b0;
        ValidMask = 4'hF; LockMask = 4'h0; FlushReq = 1'b0;
        m_busy = 1'b1; m_cnt = 0; m_clear();

        #2;
        chk("rst_busy", InitBusy, 1);
        chk("rst_valid", LRU_Valid, 0);
        chk("rst_way", LRU_Way, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_init("init_len");

        victim_is("post_rst", 0, 4'hF, 4'h0, 1, 0);

        step(1, 2, 0, 0, 0, 0, 1, 0);
        victim_is("rd_w0", 2, 4'hF, 4'h0, 1, 2);
        step(1, 2, 2, 0, 0, 0, 1, 0);
        victim_is("rd_w2", 2, 4'hF, 4'h0, 1, 1);
        victim_is("set1", 1, 4'hF, 4'h0, 1, 0);

        step(1, 3, 0, 1, 3, 2, 1, 0);
        victim_is("merge", 3, 4'hF, 4'h0, 1, 1);

        step(1, 1, 0, 0, 0, 0, 0, 0);
        victim_is("no_upd_en", 1, 4'hF, 4'h0, 1, 0);

        victim_is("lk0011", 0, 4'hF, 4'b0011, 1, 2);
        victim_is("lk1111", 0, 4'hF, 4'b1111, 0, 0);
        victim_is("vm1011", 0, 4'b1011, 4'h0, 1, 2);
        victim_is("vm_lk", 0, 4'b1011, 4'b0100, 1, 0);

        step(1, 0, 2, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        victim_is("pre_flush", 0, 4'hF, 4'h0, 1, 3);

        step(0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < SETS; i++) begin
            #1;
            chk("flush_busy", InitBusy, 1);
            chk("flush_valid", LRU_Valid, 0);
            step(1, 0, 3, 1, 0, 1, 1, 0);
        end
        #1;
        chk("flush_done", InitBusy, 0);
        victim_is("post_flush", 0, 4'hF, 4'h0, 1, 0);

        step(0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", InitBusy, 1);
        chk("mid_rst_valid", LRU_Valid, 0);
        @(negedge clk);
        rst = 1'b1;
        wait_init("mid_rst_len");

        for (int it = 0; it < 400; it++) begin
            logic [3:0] vm, lk;
            step($urandom_range(0, 1), $urandom_range(0, SETS - 1), $urandom_range(0, WAYS - 1),
                 $urandom_range(0, 1), $urandom_range(0, SETS - 1), $urandom_range(0, WAYS - 1),
                 $urandom_range(0, 7) != 0, $urandom_range(0, 49) == 0);
            vm = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            lk = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            check_model($urandom_range(0, SETS - 1), vm, lk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/plru_tree.md
# plru_tree

Parametrised tree pseudo-LRU replacement controller for N-way set-associative caches, the next generation of the 4-way PLRU. It holds WAYS-1 tree bits per set and updates them on read hits and fills. It returns a victim way for the fill set, with invalid-way priority and per-way lock exclusion. It sits beside the tag/data arrays in the I-cache and D-cache controllers and adds a self-sequenced init/flush sweep.

## Interface
- SETS, 256, number of sets; power of 2, ≥2.
- WAYS, 8, associativity; power of 2, 2..16.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- UpdateEn  in  1  1 ⇒ tree updates permitted this cycle.
- ReadSet  in  $clog2(SETS)  set of read hit.
- ReadWay  in  $clog2(WAYS)  way hit on read.
- ReadAccess  in  1  read hit valid.
- WriteSet  in  $clog2(SETS)  fill set; also the victim lookup set.
- WriteWay  in  $clog2(WAYS)  way being filled (may be tied to LRU_Way externally).
- WriteAccess  in  1  fill valid.
- ValidMask  in  WAYS  valid bits of WriteSet's ways.
- LockMask  in  WAYS  1 ⇒ way excluded from victim choice.
- FlushReq  in  1  single-cycle pulse; reinitialise all tree state.
- LRU_Way  out  $clog2(WAYS)  victim way for WriteSet.
- LRU_Valid  out  1  victim is usable.
- InitBusy  out  1  init/flush sweep in progress.

## Operation
- Tree encoding: heap order, node 0 is the root, children of node i are 2i+1 and 2i+2. Bit 0 ⇒ victim in lower-index half; bit 1 ⇒ upper half.
- An access to way w sets every node on w's path to point away from w. Off-path nodes keep their values.
- Storage: register array SETS×(WAYS-1) with combinational read and synchronous write. The array is not reset; it is cleared by the sweep.
- FSM states:
  - INIT: entered on reset assertion or from IDLE on FlushReq. A set counter runs 0..SETS-1, writing all-zero to one set per cycle. At SETS-1 the FSM goes to IDLE.
  - IDLE: normal operation.
- FlushReq during INIT is ignored; the sweep is not restarted.
- Updates are applied only in IDLE with UpdateEn=1:
  - ReadAccess alone: update ReadSet with ReadWay.
  - WriteAccess alone: update WriteSet with WriteWay.
  - Both, different sets: both sets are updated in the same cycle.
  - Both, same set: the read update is applied first, then the write update on its result. One merged write is performed and WriteWay ends as MRU. A write is never dropped.
- Victim selection is combinational on WriteSet. Priority order:
  1. The lowest-index way with ValidMask=0 and LockMask=0.
  2. Otherwise a tree walk from the root. At each node, if every way under the indicated child is locked, take the other child.
  3. If all WAYS are locked, or InitBusy=1: LRU_Valid=0, LRU_Way=0.
- Update inputs are ignored while InitBusy=1. ValidMask and LockMask never modify the tree.

## Timing
- Reset (rst=0): FSM=INIT, counter=0, InitBusy=1, LRU_Valid=0, LRU_Way=0.
- After rst deasserts, InitBusy stays high for exactly SETS rising edges, then drops.
- FlushReq sampled high in IDLE: InitBusy=1 from the next cycle, for SETS cycles. Any update presented in the FlushReq cycle is still applied.
- Update latency: new tree bits are visible on LRU_Way one cycle after the update edge. There is no same-cycle bypass.
- Victim path is zero-latency combinational from WriteSet, ValidMask, LockMask and the array.
- Reset asserted mid-sweep or mid-operation: immediate return to INIT with counter=0. Array contents are undefined until the sweep completes.

## Structure
- Package plru_pkg holds:
  - the FSM state enum (INIT, IDLE);
  - functions for node index ↔ way path and the path-update mask;
  - a WAYS-1 width helper.
- Sub-module plru_tree_update: purely combinational. Inputs are old tree bits and a way; output is the new tree bits. It is instantiated twice and chained for the same-set merge.
- Victim walk and lock steering are a generate loop over tree levels in the top module.

## Test plan
- Reset, SETS=4, WAYS=4: InitBusy high for 4 cycles after release, then low. LRU_Way=0, LRU_Valid=1 with ValidMask=1111, LockMask=0.
- Read way0 on set 2, then read way2 on set 2: LRU_Way for set 2 is 2, then 1. Set 1 is unaffected (stays 0).
- Post-reset, ReadAccess way0 and WriteAccess way2 both on set 3 in one cycle: next cycle victim is 1, showing both updates were applied.
- Post-reset, LockMask=0011: victim 2. LockMask=1111: LRU_Valid=0, LRU_Way=0.
- Post-reset, ValidMask=1011: victim 2. Add LockMask=0100: victim 0 from the tree walk.
- Accesses until set 0 victim is 3, then FlushReq: InitBusy high for 4 cycles, updates ignored during the sweep, victim 0 afterwards. rst pulsed mid-sweep restarts the count.
